warp_issue_scheduler: RTL and testbench

// - Round-robin warp scheduler that selects one ready warp per cycle for the issue stage of the SIMT core.
// - Tracks per-warp busy state: a warp is scheduled once, then is not eligible again until the pipeline signals

---
 rtl/gpgpu_sched_pkg.sv | 14 +
 rtl/warp_rr_pick.sv | 40 ++++
 rtl/warp_issue_scheduler.sv | 75 +++++++
 tb/tb_warp_issue_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/gpgpu_sched_pkg.sv
// Shared types and sizing helpers for the SIMT warp scheduling blocks.
package gpgpu_sched_pkg;

    localparam int NUM_WARPS_DEF = 8;

    function automatic int warp_id_w(input int n);
        return $clog2(n);
    endfunction

    localparam int WARP_ID_W_DEF = warp_id_w(NUM_WARPS_DEF);

    typedef logic [WARP_ID_W_DEF-1:0] warp_id_t;

endpackage

// File: rtl/warp_rr_pick.sv
// Combinational round-robin selector: lowest eligible warp above last_ptr,
// falling back to the lowest eligible warp overall.
module warp_rr_pick
    import gpgpu_sched_pkg::*;
#(
    parameter int NUM_WARPS = NUM_WARPS_DEF,
    parameter int WARP_ID_W = warp_id_w(NUM_WARPS)
) (
    input  logic [NUM_WARPS-1:0] eligible,
    input  logic [WARP_ID_W-1:0] last_ptr,
    output logic [WARP_ID_W-1:0] pick,
    output logic                 pick_valid
);

    logic [NUM_WARPS-1:0] hi_mask;
    logic [NUM_WARPS-1:0] hi;

    function automatic logic [WARP_ID_W-1:0] lowest_idx(input logic [NUM_WARPS-1:0] v);
        logic [WARP_ID_W-1:0] idx;
        idx = '0;
        // Scanning downward leaves the lowest set index as the final write.
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            if (v[i]) idx = WARP_ID_W'(i);
        end
        return idx;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        hi_mask = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            hi_mask[i] = (WARP_ID_W'(i) > last_ptr);
        end
    end

    assign hi         = eligible & hi_mask;
    assign pick       = (|hi) ? lowest_idx(hi) : lowest_idx(eligible);
    assign pick_valid = |eligible;

endmodule

// File: rtl/warp_issue_scheduler.sv
// Round-robin warp issue scheduler with per-warp busy tracking and a
// registered valid/ready issue slot toward the operand-collect stage.
module warp_issue_scheduler
    import gpgpu_sched_pkg::*;
#(
    parameter int NUM_WARPS = NUM_WARPS_DEF,
    parameter int WARP_ID_W = warp_id_w(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NUM_WARPS-1:0] warp_ready,
    input  logic [NUM_WARPS-1:0] warp_release,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [WARP_ID_W-1:0] issue_warp_id,
    output logic [NUM_WARPS-1:0] busy_mask
);

    localparam logic [NUM_WARPS-1:0] ONE = {{(NUM_WARPS-1){1'b0}}, 1'b1};
    localparam logic [WARP_ID_W-1:0] LAST_INIT = WARP_ID_W'(NUM_WARPS - 1);

    logic [NUM_WARPS-1:0] busy;
    logic [WARP_ID_W-1:0] last_ptr;
    logic [NUM_WARPS-1:0] eligible;
    logic [WARP_ID_W-1:0] pick;
    logic                 pick_valid;
    logic                 slot_free;
    logic                 load;
    logic [NUM_WARPS-1:0] held_mask;
    logic [NUM_WARPS-1:0] release_eff;
    logic [NUM_WARPS-1:0] load_mask;

    assign eligible  = warp_ready & ~busy;
    assign slot_free = ~issue_valid | issue_ready;
    assign load      = slot_free & pick_valid;

    // The warp sitting in the slot (fired or not) cannot be released yet.
    assign held_mask   = issue_valid ? (ONE << issue_warp_id) : '0;
    assign release_eff = warp_release & busy & ~held_mask;
    assign load_mask   = load ? (ONE << pick) : '0;

    warp_rr_pick #(
        .NUM_WARPS (NUM_WARPS),
        .WARP_ID_W (WARP_ID_W)
    ) u_pick (
        .eligible   (eligible),
        .last_ptr   (last_ptr),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            issue_valid   <= 1'b0;
            issue_warp_id <= '0;
            busy          <= '0;
            last_ptr      <= LAST_INIT;
        end else begin
            busy <= (busy & ~release_eff) | load_mask;
            if (slot_free) begin
                issue_valid <= pick_valid;
                if (pick_valid) begin
                    issue_warp_id <= pick;
                    last_ptr      <= pick;
                end
            end
        end
    end

    assign busy_mask = busy;

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed and randomized check of warp_issue_scheduler against a rotating-search reference model.
module tb_warp_issue_scheduler;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic [N-1:0] warp_ready = '0;
    logic [N-1:0] warp_release = '0;
    logic         issue_valid;
    logic         issue_ready = 1'b0;
    logic [2:0]   issue_warp_id;
    logic [N-1:0] busy_mask;

    int total = 0;
    int bad = 0;

    // Reference model state
    bit m_busy[N];
    bit m_valid;
    int m_id;
    int m_last;
    int fired_q[$];

    warp_issue_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .warp_ready    (warp_ready),
        .warp_release  (warp_release),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_warp_id (issue_warp_id),
        .busy_mask     (busy_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] model_busy_vec();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // Advance the model by one clock using the values about to be sampled.
    task automatic model_step(input logic [N-1:0] rdy, input logic [N-1:0] rel,
                              input logic irdy, input logic r, input logic fl);
        int  pk;
        bit  clr[N];
        if (r || fl) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_valid = 0;
            m_id    = 0;
            m_last  = N - 1;
            return;
        end
        if (m_valid && irdy) fired_q.push_back(m_id);
        pk = -1;
        for (int k = 1; k <= N; k++) begin
            int w;
            w = (m_last + k) % N;
            if (pk < 0 && rdy[w] && !m_busy[w]) pk = w;
        end
        for (int i = 0; i < N; i++) clr[i] = rel[i] && m_busy[i] && !(m_valid && m_id == i);
        for (int i = 0; i < N; i++) if (clr[i]) m_busy[i] = 0;
        if (!m_valid || irdy) begin
            if (pk >= 0) begin
                m_valid    = 1;
                m_id       = pk;
                m_busy[pk] = 1;
                m_last     = pk;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] rdy, input logic [N-1:0] rel, input logic irdy,
                         input logic r, input logic fl, input string tag);
        warp_ready   = rdy;
        warp_release = rel;
        issue_ready  = irdy;
        rst          = r;
        flush        = fl;
        model_step(rdy, rel, irdy, r, fl);
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, 32'(issue_valid), 32'(m_valid));
        chk({tag, ".id"}, 32'(issue_warp_id), 32'(m_id));
        chk({tag, ".busy"}, 32'(busy_mask), 32'(model_busy_vec()));
    endtask

    initial begin
        int fire_now;
        int prev_fire;
        logic [N-1:0] rel;

        // Reset state
        cycle('0, '0, 1'b0, 1'b1, 1'b0, "reset");
        cycle('0, '0, 1'b0, 1'b1, 1'b0, "reset");
        chk("reset_valid", 32'(issue_valid), 32'd0);
        chk("reset_busy", 32'(busy_mask), 32'd0);

        // Sweep 0..7 then all busy
        for (int k = 0; k < N; k++) begin
            cycle(8'hFF, '0, 1'b1, 1'b0, 1'b0, "sweep");
            chk("sweep_id", 32'(issue_warp_id), 32'(k));
            chk("sweep_valid", 32'(issue_valid), 32'd1);
        end
        cycle(8'hFF, '0, 1'b1, 1'b0, 1'b0, "sweep_end");
        chk("sweep_end_valid", 32'(issue_valid), 32'd0);
        chk("sweep_end_busy", 32'(busy_mask), 32'hFF);

        // Wrap-around from last_ptr=7
        cycle(8'h22, 8'h22, 1'b1, 1'b0, 1'b0, "wrap_rel");
        cycle(8'h22, '0, 1'b1, 1'b0, 1'b0, "wrap1");
        chk("wrap_first", 32'(issue_warp_id), 32'd1);
        cycle(8'h22, '0, 1'b1, 1'b0, 1'b0, "wrap2");
        chk("wrap_second", 32'(issue_warp_id), 32'd5);

        // Backpressure
        cycle('0, '0, 1'b0, 1'b1, 1'b0, "bp_reset");
        cycle(8'h0C, '0, 1'b0, 1'b0, 1'b0, "bp_load");
        for (int k = 0; k < 3; k++) begin
            cycle(8'h0C, '0, 1'b0, 1'b0, 1'b0, "bp_stall");
            chk("bp_hold_id", 32'(issue_warp_id), 32'd2);
            chk("bp_hold_valid", 32'(issue_valid), 32'd1);
        end
        cycle(8'h0C, '0, 1'b1, 1'b0, 1'b0, "bp_fire");
        chk("bp_next_id", 32'(issue_warp_id), 32'd3);

        // Fairness between warps 0 and 7
        cycle('0, '0, 1'b0, 1'b1, 1'b0, "fair_reset");
        fired_q.delete();
        prev_fire = -1;
        for (int k = 0; k < 10; k++) begin
            fire_now = m_valid ? m_id : -1;
            rel = (prev_fire >= 0) ? (N'(1) << prev_fire) : '0;
            cycle(8'h81, rel, 1'b1, 1'b0, 1'b0, "fair");
            prev_fire = fire_now;
        end
        chk("fair_count", 32'(fired_q.size() >= 4), 32'd1);
        if (fired_q.size() >= 4) begin
            chk("fair_0", 32'(fired_q[0]), 32'd0);
            chk("fair_1", 32'(fired_q[1]), 32'd7);
            chk("fair_2", 32'(fired_q[2]), 32'd0);
            chk("fair_3", 32'(fired_q[3]), 32'd7);
        end

        // Flush mid-stall
        cycle('0, '0, 1'b0, 1'b1, 1'b0, "fl_reset");
        cycle(8'h10, '0, 1'b1, 1'b0, 1'b0, "fl_load");
        chk("fl_load_id", 32'(issue_warp_id), 32'd4);
        cycle(8'h10, '0, 1'b0, 1'b0, 1'b0, "fl_stall");
        cycle(8'h10, '0, 1'b0, 1'b0, 1'b1, "fl_flush");
        chk("fl_valid", 32'(issue_valid), 32'd0);
        chk("fl_busy", 32'(busy_mask), 32'd0);
        cycle(8'h11, '0, 1'b1, 1'b0, 1'b0, "fl_after");
        chk("fl_after_id", 32'(issue_warp_id), 32'd0);

        // Illegal releases
        cycle('0, '0, 1'b0, 1'b1, 1'b0, "il_reset");
        cycle(8'h08, '0, 1'b0, 1'b0, 1'b0, "il_load");
        cycle(8'h08, 8'h48, 1'b0, 1'b0, 1'b0, "il_rel");
        chk("il_busy3", 32'(busy_mask[3]), 32'd1);
        chk("il_busy6", 32'(busy_mask[6]), 32'd0);
        cycle(8'h08, '0, 1'b1, 1'b0, 1'b0, "il_fire");
        chk("il_no_dup", 32'(issue_valid), 32'd0);
        chk("il_busy_after", 32'(busy_mask), 32'h08);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r_rdy;
            logic [N-1:0] r_rel;
            r_rdy = N'($urandom) | N'($urandom);
            r_rel = N'($urandom) & N'($urandom);
            cycle(r_rdy, r_rel, 1'($urandom_range(0, 3) != 0), 1'b0,
                  1'($urandom_range(0, 49) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
